ram_byte_reader: RTL and testbench
==================================

RAM_BYTE_READER -- requirements
Module: ram_byte_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, byte address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles waited for mem_rvalid after mem_ack.
REQ-003 SHALL have parameter CACHE_EN, default 1; 0 disables the word cache, so every request misses.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have these ports:
- ram_addr input ADDR_W: byte address of request.
- in_valid input 1: request strobe.
- busy output 1: request in progress; in_valid ignored while high.
- data_out output 8: read byte.
- out_valid output 1: one-cycle response strobe.
- err output 1: qualifies out_valid; response timed out.
- cache_inv input 1: invalidate cached word.
- mem_addr output ADDR_W-1: word address to memory.
- mem_rd_req output 1: memory read request.
- mem_ack input 1: memory accepted request.
- mem_rdata input 16: read word.
- mem_rvalid input 1: mem_rdata valid.
- hit_cnt output 16: saturating cache-hit count.
- miss_cnt output 16: saturating cache-miss count.

Function
REQ-006 SHALL accept a request when in_valid=1 and busy=0.
- Word address = ram_addr[ADDR_W-1:1].
- Byte select = ram_addr[0]: 0 selects mem_rdata[7:0]; 1 selects mem_rdata[15:8].
REQ-007 SHALL hold a cache of one word: valid, tag (ADDR_W-1), data (16).
- Hit = CACHE_EN & valid & tag == request word address & !cache_inv in the same cycle.
REQ-008 SHALL respond to a hit accepted in cycle N with out_valid=1, err=0 and the selected byte in N+1.
- busy stays 0 for a hit.
- No memory access is made.
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, RESP.
- IDLE->ISSUE on accepted miss.
- ISSUE->WAIT on mem_ack.
- WAIT->RESP on mem_rvalid or on timeout.
- RESP->IDLE unconditionally.
REQ-010 SHALL assert busy from N+1 for a miss accepted in cycle N, through the last WAIT cycle; busy=0 in RESP.
REQ-011 SHALL hold mem_rd_req=1 and mem_addr stable in ISSUE until mem_ack=1; mem_rd_req=0 in all other states.
REQ-012 SHALL, on mem_rvalid in WAIT, capture mem_rdata and load the cache (valid=1, tag=word address); RESP then drives out_valid=1, err=0 and the selected byte.
REQ-013 SHALL count WAIT cycles from 0; if the count reaches TIMEOUT without mem_rvalid, RESP drives out_valid=1, err=1, data_out=8'h00, and the cache is not updated.
REQ-014 SHALL ignore mem_rvalid and mem_ack outside WAIT and ISSUE respectively.
REQ-015 SHALL hold data_out until the next response; out_valid and err are single-cycle.
REQ-016 SHALL clear cache valid on cache_inv in any state.
- If cache_inv coincides with a mem_rvalid load, the load wins (valid=1).
REQ-017 SHALL increment hit_cnt per hit and miss_cnt per accepted miss, each saturating at 16'hFFFF.
REQ-018 SHALL accept a new request in the RESP cycle, since busy=0 there.

Reset
REQ-019 SHALL, on rst_n=0 (asynchronous, any state, including mid-transaction), force:
- state=IDLE
- busy=0, out_valid=0, err=0, data_out=8'h00
- mem_rd_req=0, mem_addr=0
- cache valid=0, tag=0, data=0
- timeout counter=0, hit_cnt=0, miss_cnt=0
REQ-020 SHALL discard any mem_rvalid arriving after reset release for a request issued before reset.

Structure
REQ-021 SHALL place the state encoding, the 16-bit counter width and default ADDR_W in shared package ram_pkg.
REQ-022 SHALL implement the one-word cache (valid/tag/data registers, hit compare, invalidate/load priority) as sub-module ram_line_cache.

Verification
REQ-023 Miss then hit:
- Read 23'h000010: mem_rd_req with mem_addr=22'h000008; mem_ack next cycle; mem_rvalid 3 cycles later with mem_rdata=16'hBEEF -> out_valid with data_out=8'hEF, miss_cnt=1.
- Then read 23'h000011 -> out_valid one cycle after in_valid, data_out=8'hBE, mem_rd_req stays 0, hit_cnt=1.
REQ-024 Backpressure: hold mem_ack=0 for 10 cycles -> mem_rd_req and mem_addr stable all 10 cycles, busy=1 throughout.
REQ-025 Timeout: TIMEOUT=8, mem_rvalid never asserted -> out_valid=1, err=1, data_out=8'h00 after 8 WAIT cycles; a reread of the same address misses.
REQ-026 Invalidate: load 23'h000010, then assert cache_inv in the same cycle as a read of 23'h000010 -> treated as miss, mem_rd_req asserted.
REQ-027 Reset mid-op: drop rst_n in WAIT -> busy=0 and mem_rd_req=0 immediately; a subsequent stray mem_rvalid produces no out_valid.
REQ-028 Saturation: force 65536 hits -> hit_cnt=16'hFFFF and stays there.

Source files
------------

// File: rtl/ram_pkg.sv
// Definitions shared by the byte reader and its line cache: FSM encoding,
// statistics counter width, default address width and small helpers.
package ram_pkg;

   localparam int ADDR_W_DEF = 23;
   localparam int CNT_W      = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef logic [CNT_W-1:0] cnt_t;

   // Byte lane 0 is the low half of the memory word.
   function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic sel);
      return sel ? word[15:8] : word[7:0];
   endfunction

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ram_line_cache.sv
// One-word read cache: valid/tag/data registers, same-cycle hit compare and
// invalidate-versus-fill priority.
module ram_line_cache
   import ram_pkg::*;
#(
   parameter int TAG_W    = ADDR_W_DEF - 1,
   parameter int CACHE_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [TAG_W-1:0] lookup_tag,
   input  logic             inv,
   input  logic             load_en,
   input  logic [TAG_W-1:0] load_tag,
   input  logic [15:0]      load_data,
   output logic             hit,
   output logic [15:0]      line_data
);

   logic             valid_q, valid_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [15:0]      data_q, data_d;

   always_comb begin
      // NOTE: each _d starts from its _q value so no branch below can leave it unassigned and infer a latch.
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (inv) valid_d = 1'b0;
      // A fill arriving together with an invalidate wins: the word is fresh.
      if (load_en) begin
         valid_d = 1'b1;
         tag_d   = load_tag;
         data_d  = load_data;
      end
   end

   // NOTE: the line is a handful of flops, so tag and data are reset along with valid; no X reaches the compare.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

   assign hit       = (CACHE_EN != 0) && valid_q && (tag_q == lookup_tag) && !inv;
   assign line_data = data_q;

endmodule

// File: rtl/ram_byte_reader.sv
// Byte-granular reader in front of a 16-bit word memory, with a one-word cache,
// bounded wait for read data and saturating hit/miss statistics.
module ram_byte_reader
   import ram_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int TIMEOUT  = 255,
   parameter int CACHE_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] ram_addr,
   input  logic              in_valid,
   output logic              busy,
   output logic [7:0]        data_out,
   output logic              out_valid,
   output logic              err,
   input  logic              cache_inv,
   output logic [ADDR_W-2:0] mem_addr,
   output logic              mem_rd_req,
   input  logic              mem_ack,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
);

   localparam int WORD_W = ADDR_W - 1;
   localparam int TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [1:0]        state_q, state_d;
   logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
   logic              byte_sel_q, byte_sel_d;
   logic              out_valid_q, out_valid_d;
   logic              err_q, err_d;
   logic [7:0]        data_out_q, data_out_d;
   cnt_t              hit_cnt_q, hit_cnt_d;
   cnt_t              miss_cnt_q, miss_cnt_d;

   logic              cache_hit;
   logic [15:0]       line_data;
   logic              accept, acc_hit, acc_miss;
   logic              fill, timed_out;

   assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign accept    = in_valid && !busy;
   assign acc_hit   = accept && cache_hit;
   assign acc_miss  = accept && !cache_hit;

   // Data beats win over the timeout in the last permitted WAIT cycle.
   assign fill      = (state_q == ST_WAIT) && mem_rvalid;
   assign timed_out = (state_q == ST_WAIT) && !mem_rvalid &&
                      (wait_cnt_q == TO_W'(TIMEOUT - 1));

   ram_line_cache #(
      .TAG_W    (WORD_W),
      .CACHE_EN (CACHE_EN)
   ) u_cache (
      .clk        (clk),
      .rst_n      (rst_n),
      .lookup_tag (ram_addr[ADDR_W-1:1]),
      .inv        (cache_inv),
      .load_en    (fill),
      .load_tag   (mem_addr_q),
      .load_data  (mem_rdata),
      .hit        (cache_hit),
      .line_data  (line_data)
   );

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      mem_addr_d = mem_addr_q;
      byte_sel_d = byte_sel_q;
      data_out_d = data_out_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;

      case (state_q)
         ST_IDLE:  if (acc_miss) state_d = ST_ISSUE;
         ST_ISSUE: if (mem_ack) state_d = ST_WAIT;
         ST_WAIT:  if (fill || timed_out) state_d = ST_RESP;
         // RESP has busy low, so a miss accepted here goes straight to ISSUE.
         ST_RESP:  state_d = acc_miss ? ST_ISSUE : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if ((state_q == ST_WAIT) && !fill && !timed_out) wait_cnt_d = wait_cnt_q + 1'b1;

      if (acc_miss) begin
         mem_addr_d = ram_addr[ADDR_W-1:1];
         byte_sel_d = ram_addr[0];
      end

      out_valid_d = acc_hit || fill || timed_out;
      err_d       = timed_out;

      if (acc_hit)        data_out_d = pick_byte(line_data, ram_addr[0]);
      else if (fill)      data_out_d = pick_byte(mem_rdata, byte_sel_q);
      else if (timed_out) data_out_d = 8'h00;

      if (acc_hit)  hit_cnt_d  = sat_inc(hit_cnt_q);
      if (acc_miss) miss_cnt_d = sat_inc(miss_cnt_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         mem_addr_q  <= '0;
         byte_sel_q  <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         data_out_q  <= 8'h00;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_addr_q  <= mem_addr_d;
         byte_sel_q  <= byte_sel_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         data_out_q  <= data_out_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign mem_rd_req = (state_q == ST_ISSUE);
   assign mem_addr   = mem_addr_q;
   assign out_valid  = out_valid_q;
   assign err        = err_q;
   assign data_out   = data_out_q;
   assign hit_cnt    = hit_cnt_q;
   assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_ram_byte_reader.sv
// Self-checking bench for ram_byte_reader: directed vector table, reset and
// saturation sequences, then randomized traffic against a transaction model.
module tb_ram_byte_reader;

   localparam int TO = 8;

   logic        clk;
   logic        rst_n;
   logic [22:0] ram_addr;
   logic        in_valid;
   logic        busy;
   logic [7:0]  data_out;
   logic        out_valid;
   logic        err;
   logic        cache_inv;
   logic [21:0] mem_addr;
   logic        mem_rd_req;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   ram_byte_reader #(
      .ADDR_W   (23),
      .TIMEOUT  (TO),
      .CACHE_EN (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ram_addr   (ram_addr),
      .in_valid   (in_valid),
      .busy       (busy),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .err        (err),
      .cache_inv  (cache_inv),
      .mem_addr   (mem_addr),
      .mem_rd_req (mem_rd_req),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] addr;
      logic        inv;
      logic        inv_rv;
      int          ack_dly;
      int          rv_dly;
      logic        no_rv;
      logic [15:0] rdata;
      logic        exp_hit;
      logic [7:0]  exp_data;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      check("idle_wait", 32'(busy), 32'(0));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; cache_inv = 1'b0;
      mem_ack = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One request from issue to response; inputs change only at negedges.
   task automatic do_req(input logic [22:0] addr, input logic inv, input logic inv_rv,
                         input int ack_dly, input int rv_dly, input logic no_rv,
                         input logic [15:0] rdata, input logic exp_hit,
                         input logic [7:0] exp_data, input logic exp_err);
      int n;
      logic [21:0] w;
      w = addr[22:1];
      wait_idle();
      ram_addr = addr; in_valid = 1'b1; cache_inv = inv;
      step();
      in_valid = 1'b0; cache_inv = 1'b0; ram_addr = 23'($urandom);
      if (exp_hit) begin
         check("hit_no_req", 32'(mem_rd_req), 32'(0));
         check("hit_busy", 32'(busy), 32'(0));
      end else begin
         check("miss_busy", 32'(busy), 32'(1));
         check("miss_req", 32'(mem_rd_req), 32'(1));
         check("miss_addr", 32'(mem_addr), 32'(w));
         for (int i = 0; i < ack_dly; i++) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = 16'($urandom);
            step();
            check("bp_req", 32'(mem_rd_req), 32'(1));
            check("bp_addr", 32'(mem_addr), 32'(w));
            check("bp_busy", 32'(busy), 32'(1));
         end
         mem_rvalid = 1'b0; mem_ack = 1'b1;
         step();
         mem_ack = 1'b0;
         if (no_rv) begin
            n = 0;
            while (!out_valid && n < 20) begin
               mem_ack = 1'($urandom_range(0, 1));
               step();
               n++;
            end
            mem_ack = 1'b0;
            check("to_cycles", 32'(n), 32'(TO));
         end else begin
            for (int i = 0; i < rv_dly; i++) begin
               check("wait_quiet", 32'(out_valid), 32'(0));
               check("wait_busy", 32'(busy), 32'(1));
               check("wait_noreq", 32'(mem_rd_req), 32'(0));
               mem_ack = 1'($urandom_range(0, 1));
               step();
            end
            mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata; cache_inv = inv_rv;
            step();
            mem_rvalid = 1'b0; cache_inv = 1'b0; mem_rdata = 16'($urandom);
         end
      end
      check("resp_valid", 32'(out_valid), 32'(1));
      check("resp_err", 32'(err), 32'(exp_err));
      check("resp_data", 32'(data_out), 32'(exp_data));
      check("resp_busy", 32'(busy), 32'(0));
   endtask

   // Reference model state: one cached word and the hit/miss tallies.
   logic        m_valid;
   logic [21:0] m_tag;
   logic [15:0] m_data;
   int          m_hits, m_misses;
   logic [21:0] pool[4];

   initial begin
      int eh, em;
      rst_n = 1'b0; in_valid = 1'b0; ram_addr = '0; cache_inv = 1'b0;
      mem_ack = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ovalid", 32'(out_valid), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      check("rst_data", 32'(data_out), 32'(0));
      check("rst_req", 32'(mem_rd_req), 32'(0));
      check("rst_maddr", 32'(mem_addr), 32'(0));
      check("rst_hits", 32'(hit_cnt), 32'(0));
      check("rst_miss", 32'(miss_cnt), 32'(0));
      rst_n = 1'b1;

      //            addr        inv  inv_rv ack rv no_rv rdata     hit  data   err
      vecs[0]  = '{23'h000010, 1'b0, 1'b0, 1, 2, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0};
      vecs[1]  = '{23'h000011, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b1, 8'hBE, 1'b0};
      vecs[2]  = '{23'h000020, 1'b0, 1'b0, 10, 0, 1'b0, 16'h1234, 1'b0, 8'h34, 1'b0};
      vecs[3]  = '{23'h000021, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b1, 8'h12, 1'b0};
      vecs[4]  = '{23'h000011, 1'b0, 1'b0, 0, 7, 1'b0, 16'hBEEF, 1'b0, 8'hBE, 1'b0};
      vecs[5]  = '{23'h000010, 1'b1, 1'b0, 0, 0, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0};
      vecs[6]  = '{23'h000040, 1'b0, 1'b0, 0, 0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b1};
      vecs[7]  = '{23'h000040, 1'b0, 1'b0, 0, 1, 1'b0, 16'hCAFE, 1'b0, 8'hFE, 1'b0};
      vecs[8]  = '{23'h000041, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b1, 8'hCA, 1'b0};
      vecs[9]  = '{23'h000010, 1'b0, 1'b0, 2, 3, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0};
      vecs[10] = '{23'h000080, 1'b0, 1'b1, 0, 1, 1'b0, 16'h7711, 1'b0, 8'h11, 1'b0};
      vecs[11] = '{23'h000081, 1'b0, 1'b0, 0, 0, 1'b0, 16'h0000, 1'b1, 8'h77, 1'b0};

      eh = 0; em = 0;
      for (int i = 0; i < 12; i++) begin
         do_req(vecs[i].addr, vecs[i].inv, vecs[i].inv_rv, vecs[i].ack_dly, vecs[i].rv_dly,
                vecs[i].no_rv, vecs[i].rdata, vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_err);
         if (vecs[i].exp_hit) eh++; else em++;
         step();
         check("hold_ovalid", 32'(out_valid), 32'(0));
         check("hold_err", 32'(err), 32'(0));
         check("hold_data", 32'(data_out), 32'(vecs[i].exp_data));
         check("tbl_hits", 32'(hit_cnt), 32'(eh));
         check("tbl_miss", 32'(miss_cnt), 32'(em));
      end

      // Reset in the middle of a WAIT, then a stray data beat.
      wait_idle();
      ram_addr = 23'h000200; in_valid = 1'b1;
      step();
      in_valid = 1'b0; mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      step();
      check("mid_busy_pre", 32'(busy), 32'(1));
      #1 rst_n = 1'b0;
      #1;
      check("mid_busy", 32'(busy), 32'(0));
      check("mid_req", 32'(mem_rd_req), 32'(0));
      check("mid_maddr", 32'(mem_addr), 32'(0));
      check("mid_data", 32'(data_out), 32'(0));
      check("mid_hits", 32'(hit_cnt), 32'(0));
      check("mid_miss", 32'(miss_cnt), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
      step();
      mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("stray_rvalid", 32'(out_valid), 32'(0));
         step();
      end
      do_req(23'h000010, 1'b0, 1'b0, 0, 0, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0);

      // Randomized traffic against the transaction model.
      do_reset();
      pool[0] = 22'h000000; pool[1] = 22'h000001; pool[2] = 22'h3FFFFF; pool[3] = 22'h155555;
      m_valid = 1'b0; m_tag = '0; m_data = '0; m_hits = 0; m_misses = 0;
      for (int t = 0; t < 200; t++) begin
         logic [22:0] a;
         logic        inv, inv_rv, no_rv, hit_e, err_e;
         logic [15:0] rd;
         logic [7:0]  exp_b;
         int          ack_d, rv_d;
         a      = {pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1))};
         inv    = ($urandom_range(0, 4) == 0);
         inv_rv = ($urandom_range(0, 4) == 0);
         no_rv  = ($urandom_range(0, 5) == 0);
         ack_d  = $urandom_range(0, 3);
         rv_d   = $urandom_range(0, TO - 1);
         rd     = 16'($urandom);
         hit_e  = m_valid && (m_tag == a[22:1]) && !inv;
         err_e  = 1'b0;
         if (inv) m_valid = 1'b0;
         if (hit_e) begin
            exp_b = a[0] ? m_data[15:8] : m_data[7:0];
            m_hits++;
         end else begin
            m_misses++;
            if (no_rv) begin
               exp_b = 8'h00;
               err_e = 1'b1;
            end else begin
               m_valid = 1'b1; m_tag = a[22:1]; m_data = rd;
               exp_b = a[0] ? rd[15:8] : rd[7:0];
            end
         end
         do_req(a, inv, inv_rv, ack_d, rv_d, no_rv, rd, hit_e, exp_b, err_e);
         check("rnd_hits", 32'(hit_cnt), 32'(m_hits));
         check("rnd_miss", 32'(miss_cnt), 32'(m_misses));
         if ($urandom_range(0, 1) == 1) step();
      end

      // Hit counter saturation with back-to-back hits.
      do_reset();
      do_req(23'h000010, 1'b0, 1'b0, 0, 0, 1'b0, 16'hBEEF, 1'b0, 8'hEF, 1'b0);
      ram_addr = 23'h000010; in_valid = 1'b1;
      repeat (65534) step();
      check("sat_fffe", 32'(hit_cnt), 32'(16'hFFFE));
      step();
      check("sat_ffff", 32'(hit_cnt), 32'(16'hFFFF));
      repeat (5) step();
      check("sat_hold", 32'(hit_cnt), 32'(16'hFFFF));
      check("sat_ovalid", 32'(out_valid), 32'(1));
      check("sat_data", 32'(data_out), 32'(8'hEF));
      check("sat_miss", 32'(miss_cnt), 32'(1));
      check("sat_noreq", 32'(mem_rd_req), 32'(0));
      in_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
